// File: rtl/cmd_bus_pkg.sv
// Shared types and constants for the command-bus arbiter and the requesters that feed it.
package cmd_bus_pkg;

  localparam int CMD_DATA_W = 8;
  localparam int GID_W      = 3;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_REL  = 2'd2
  } arb_state_e;

  // Command bytes also issued by the startup sequencer
  localparam logic [CMD_DATA_W-1:0] CMD_BIST = 8'h52;
  localparam logic [CMD_DATA_W-1:0] CMD_CFG  = 8'h53;
  localparam logic [CMD_DATA_W-1:0] CMD_LOAD = 8'h54;

  // Per-cycle transfer events seen by the FSM
  typedef struct packed {
    logic accept;
    logic pkt_end;
    logic expire;
  } xfer_evt_t;

  function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] idx, input int n);
    return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/cmd_bus_arbiter_if.sv
// Requester-side and decoder-side beat channels of the shared command bus.
interface cmd_bus_arbiter_if
  import cmd_bus_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = CMD_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cmd_valid;
  logic [DATA_W-1:0]         cmd_data;
  logic                      cmd_last;
  logic                      cmd_ready;

  // Environment view: requesters plus the decoder
  modport master (
    output req_valid, req_data, req_last, cmd_ready,
    input  req_ready, cmd_valid, cmd_data, cmd_last
  );

  // Arbiter view
  modport slave (
    input  req_valid, req_data, req_last, cmd_ready,
    output req_ready, cmd_valid, cmd_data, cmd_last
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at ptr, ptr+1, ... (mod N).
module rr_pick
  import cmd_bus_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] ptr,
  output logic [GID_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Bit k of rot is req[(ptr+k) mod N]
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign any = |req;

  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_idx = (int'(ptr) + k >= N) ? GID_W'(int'(ptr) + k - N) : GID_W'(int'(ptr) + k);
      end
    end
  end

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Packet-granular round-robin arbiter for the command channel, with an owner-idle watchdog.
module cmd_bus_arbiter
  import cmd_bus_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = CMD_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  cmd_bus_arbiter_if.slave  bus,
  output logic [GID_W-1:0]  grant_id,
  output logic              busy,
  output logic              timeout_err,
  output logic [GID_W-1:0]  err_id
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e                      state, state_nxt;
  logic [GID_W-1:0]                rr_ptr, pick_idx, rel_ptr;
  logic                            pick_any;
  logic [CNT_W-1:0]                idle_cnt;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_a;
  logic                            own_valid, own_last, xfer;
  logic [DATA_W-1:0]               own_data;
  xfer_evt_t                       evt;

  assign data_a = bus.req_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Owner's lane, selected by the registered grant
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GID_W'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = data_a[i];
      end
    end
  end

  assign xfer        = (state == ST_XFER);
  assign rel_ptr     = wrap_inc(grant_id, NUM_REQ);
  assign evt.accept  = xfer & own_valid & bus.cmd_ready;
  assign evt.pkt_end = evt.accept & own_last;
  // A decoder stall keeps own_valid high, so only an absent owner can expire
  assign evt.expire  = xfer & ~own_valid & (idle_cnt == IDLE_LAST) & ~evt.pkt_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_any) state_nxt = ST_XFER;
      ST_XFER: if (evt.pkt_end || evt.expire) state_nxt = ST_REL;
      ST_REL:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = xfer;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_last  = 1'b0;
    bus.req_ready = '0;
    if (xfer) begin
      bus.cmd_valid = own_valid;
      bus.cmd_data  = own_data;
      bus.cmd_last  = own_last;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_ready[i] = (grant_id == GID_W'(i)) & bus.cmd_ready;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id    <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      err_id      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= evt.expire;
      if (state == ST_IDLE && pick_any) begin
        grant_id <= pick_idx;
        idle_cnt <= '0;
      end
      if (xfer) begin
        if (evt.accept)      idle_cnt <= '0;
        else if (!own_valid) idle_cnt <= idle_cnt + 1'b1;
        if (evt.pkt_end || evt.expire) rr_ptr <= rel_ptr;
        if (evt.expire)                err_id <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Directed scoreboard bench for cmd_bus_arbiter (TIMEOUT=4 so the watchdog is reachable quickly).
module tb_cmd_bus_arbiter;
  import cmd_bus_pkg::*;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_bus_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  logic [GID_W-1:0] grant_id, err_id;
  logic             busy, timeout_err;

  cmd_bus_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_id      (err_id)
  );

  logic          v [NR];
  logic [DW-1:0] d [NR];
  logic          l [NR];
  logic          cmd_rdy;

  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]          = v[i];
      bus.req_last[i]           = l[i];
      bus.req_data[i*DW +: DW]  = d[i];
    end
    bus.cmd_ready = cmd_rdy;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int gid; logic [DW-1:0] data; logic last; int cyc;} beat_exp_t;
  typedef struct {int gid; int cyc;} to_exp_t;
  beat_exp_t exp_q[$];
  to_exp_t   to_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_b(input int g, input logic [DW-1:0] dd, input logic ll, input int c);
    beat_exp_t e;
    e.gid = g; e.data = dd; e.last = ll; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_to(input int g, input int c);
    to_exp_t e;
    e.gid = g; e.cyc = c;
    to_q.push_back(e);
  endtask

  // Requester r presents n beats, holding each until it is accepted
  task automatic send_pkt(input int r, input int n, input logic [DW-1:0] b0,
                          input logic [DW-1:0] b1, input logic [DW-1:0] b2);
    logic ok;
    for (int i = 0; i < n; i++) begin
      v[r] = 1'b1;
      d[r] = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      l[r] = (i == n - 1);
      ok = 1'b0;
      for (int w = 0; w < 400 && !ok; w++) begin
        @(negedge clk);
        if (bus.req_ready[r]) ok = 1'b1;
        @(posedge clk); #1;
      end
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL send_pkt_wait: req %0d beat %0d never accepted", r, i);
      end
    end
    v[r] = 1'b0; l[r] = 1'b0; d[r] = '0;
  endtask

  // Monitor: every accepted beat and every timeout pulse must match the head of its queue
  always @(negedge clk) begin
    beat_exp_t eb;
    to_exp_t   et;
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_unexpected: gid %0d data %0h at cycle %0d, none expected", grant_id, bus.cmd_data, cyc);
        end else begin
          eb = exp_q.pop_front();
          chk("beat_gid", 32'(grant_id), eb.gid);
          chk("beat_data", 32'(bus.cmd_data), 32'(eb.data));
          chk("beat_last", 32'(bus.cmd_last), 32'(eb.last));
          if (eb.cyc >= 0) chk("beat_cycle", cyc, eb.cyc);
        end
      end
      if (timeout_err) begin
        if (to_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL timeout_unexpected: err_id %0d at cycle %0d, none expected", err_id, cyc);
        end else begin
          et = to_q.pop_front();
          chk("timeout_err_id", 32'(err_id), et.gid);
          chk("timeout_cycle", cyc, et.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench hung");
  end

  initial begin
    int  a;
    logic ok;
    for (int i = 0; i < NR; i++) begin v[i] = 1'b0; d[i] = '0; l[i] = 1'b0; end
    cmd_rdy = 1'b1;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_err_id", 32'(err_id), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // All three requesters, one-beat packets, two rounds: order 0,1,2 with 2 dead cycles between
    for (int rnd = 0; rnd < 2; rnd++) begin
      a = cyc;
      push_b(0, CMD_BIST, 1'b1, a + 1);
      push_b(1, CMD_CFG,  1'b1, a + 4);
      push_b(2, CMD_LOAD, 1'b1, a + 7);
      fork
        send_pkt(0, 1, CMD_BIST, 8'h00, 8'h00);
        send_pkt(1, 1, CMD_CFG,  8'h00, 8'h00);
        send_pkt(2, 1, CMD_LOAD, 8'h00, 8'h00);
      join
      tick(2);
    end

    // Single requester, 3-beat packet on consecutive cycles; released the cycle after last
    a = cyc;
    push_b(0, CMD_BIST, 1'b0, a + 1);
    push_b(0, CMD_CFG,  1'b0, a + 2);
    push_b(0, CMD_LOAD, 1'b1, a + 3);
    send_pkt(0, 3, CMD_BIST, CMD_CFG, CMD_LOAD);
    @(negedge clk);
    chk("t1_busy_after_last", 32'(busy), 0);
    chk("t1_cycle_after_last", cyc, a + 4);
    tick(2);

    // Decoder stall of 300 cycles mid-packet must not trip the watchdog
    push_b(1, CMD_CFG,  1'b0, -1);
    push_b(1, CMD_LOAD, 1'b0, -1);
    push_b(1, CMD_BIST, 1'b1, -1);
    fork
      send_pkt(1, 3, CMD_CFG, CMD_LOAD, CMD_BIST);
      begin
        tick(2);
        cmd_rdy = 1'b0;
        tick(300);
        chk("t3_busy_stall", 32'(busy), 1);
        chk("t3_gid_stall", 32'(grant_id), 1);
        chk("t3_cmd_valid_stall", 32'(bus.cmd_valid), 1);
        cmd_rdy = 1'b1;
      end
    join
    tick(2);

    // Owner 2 goes quiet after one beat: timeout pulse 4 cycles after valid drops
    a = cyc;
    push_b(2, CMD_BIST, 1'b0, a + 1);
    push_to(2, a + 6);
    v[2] = 1'b1; d[2] = CMD_BIST; l[2] = 1'b0;
    tick(2);
    v[2] = 1'b0; d[2] = '0;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      if (timeout_err) ok = 1'b1;
    end
    chk("t4_timeout_seen", 32'(ok), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_pulse_one_cycle", 32'(timeout_err), 0);
    chk("t4_busy_after", 32'(busy), 0);
    chk("t4_err_id", 32'(err_id), 2);
    @(posedge clk); #1;
    a = cyc;
    push_b(0, CMD_BIST, 1'b1, a + 1);
    push_b(1, CMD_CFG,  1'b1, a + 4);
    fork
      send_pkt(1, 1, CMD_CFG,  8'h00, 8'h00);
      send_pkt(0, 1, CMD_BIST, 8'h00, 8'h00);
    join
    tick(2);

    // Last beat arrives exactly when idle_cnt sits at TIMEOUT-1: normal release, no error
    a = cyc;
    push_b(2, CMD_CFG,  1'b0, a + 1);
    push_b(2, CMD_LOAD, 1'b1, a + 5);
    v[2] = 1'b1; d[2] = CMD_CFG; l[2] = 1'b0;
    tick(2);
    v[2] = 1'b0;
    tick(3);
    v[2] = 1'b1; d[2] = CMD_LOAD; l[2] = 1'b1;
    tick(1);
    v[2] = 1'b0; d[2] = '0; l[2] = 1'b0;
    @(negedge clk);
    chk("t5_busy_released", 32'(busy), 0);
    chk("t5_no_timeout", 32'(timeout_err), 0);
    chk("t5_err_id_held", 32'(err_id), 2);
    tick(2);

    // Move rr_ptr to 2, then reset mid-packet of owner 2
    push_b(1, CMD_CFG, 1'b1, -1);
    send_pkt(1, 1, CMD_CFG, 8'h00, 8'h00);
    tick(2);
    v[2] = 1'b1; d[2] = CMD_LOAD; l[2] = 1'b0;
    v[1] = 1'b1; d[1] = CMD_BIST; l[1] = 1'b1;
    tick(1);
    chk("t6_pre_gid", 32'(grant_id), 2);
    chk("t6_pre_cmd_valid", 32'(bus.cmd_valid), 1);
    chk("t6_pre_req_ready", 32'(bus.req_ready), 32'b100);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("t6_rst_req_ready", 32'(bus.req_ready), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_grant_id", 32'(grant_id), 0);
    chk("t6_rst_timeout_err", 32'(timeout_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_b(1, CMD_BIST, 1'b1, -1);
    push_b(2, CMD_LOAD, 1'b1, -1);
    fork
      send_pkt(1, 1, CMD_BIST, 8'h00, 8'h00);
      send_pkt(2, 1, CMD_LOAD, 8'h00, 8'h00);
    join
    tick(3);

    chk("beats_all_seen", exp_q.size(), 0);
    chk("timeouts_all_seen", to_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
